// File: rtl/orb_buf_pkg.sv
// Shared types and defaults for the orbit frame buffer: bank states, counter width, parameter defaults.
package orb_buf_pkg;

   localparam int unsigned CNT_W         = 16;
   localparam int unsigned BANK_IDX_W    = 2;
   localparam int unsigned WORD_W_DEF    = 12;
   localparam int unsigned DEPTH_DEF     = 2048;
   localparam int unsigned NBUF_DEF      = 2;
   localparam bit          REPEAT_EN_DEF = 1'b1;

   typedef enum logic [1:0] {
      BANK_FREE,
      BANK_FILLING,
      BANK_READY,
      BANK_READING
   } bank_st_e;

   // Saturating event counter step.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic hit);
      return (hit && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
   endfunction

endpackage

// File: rtl/orb_bank_ram.sv
// Frame storage for all banks: simple dual-port, registered read, single clock, no reset.
module orb_bank_ram
   import orb_buf_pkg::*;
#(
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned NWORDS = 4096
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [NWORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/orb_frame_buffer.sv
// Multi-bank orbit frame buffer: writer fills a bank, commits it, reader swaps to the newest frame at orbit boundaries.
module orb_frame_buffer
   import orb_buf_pkg::*;
#(
   parameter int unsigned       WORD_W    = WORD_W_DEF,
   parameter int unsigned       DEPTH     = DEPTH_DEF,
   parameter int unsigned       NBUF      = NBUF_DEF,
   parameter bit                REPEAT_EN = REPEAT_EN_DEF,
   parameter logic [WORD_W-1:0] FILL_WORD = '0,
   localparam int unsigned      AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [WORD_W-1:0]     wr_data,
   input  logic                  wr_commit,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [WORD_W-1:0]     rd_data,
   input  logic                  rd_swap,
   output logic                  rd_valid,
   output logic                  frame_fresh,
   output logic [BANK_IDX_W-1:0] wr_bank,
   output logic [BANK_IDX_W-1:0] rd_bank,
   output logic                  wr_wait,
   output logic [CNT_W-1:0]      overrun_cnt,
   output logic [CNT_W-1:0]      underrun_cnt,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam int unsigned BW        = $clog2(NBUF);
   localparam int unsigned MEM_WORDS = NBUF * DEPTH;

   bank_st_e          bank_st [NBUF];
   bank_st_e          st_nxt  [NBUF];
   logic [BW-1:0]     wr_bank_q, rd_bank_q;
   logic [BW-1:0]     wr_bank_nxt, rd_bank_nxt, ready_idx, deliver_idx, free_idx;
   logic              wr_wait_nxt, rd_valid_nxt, fresh_nxt;
   logic              ready_found, free_found, commit_ok, deliver, rd_release;
   logic              overrun_hit, underrun_hit, drop_hit;
   logic              fill_sel, ram_we, ram_re;
   logic [WORD_W-1:0] ram_q;

   assign wr_bank  = BANK_IDX_W'(wr_bank_q);
   assign rd_bank  = BANK_IDX_W'(rd_bank_q);
   assign drop_hit = wr_en && wr_wait;
   assign ram_we   = wr_en && !wr_wait;
   assign ram_re   = rd_en && rd_valid;
   assign rd_data  = fill_sel ? FILL_WORD : ram_q;

   // Bank ownership update: commit resolves first, then the reader swap, then the writer picks a bank.
   always_comb begin
      st_nxt       = bank_st;
      wr_bank_nxt  = wr_bank_q;
      wr_wait_nxt  = wr_wait;
      rd_bank_nxt  = rd_bank_q;
      rd_valid_nxt = rd_valid;
      fresh_nxt    = frame_fresh;
      overrun_hit  = 1'b0;
      underrun_hit = 1'b0;
      ready_found  = 1'b0;
      ready_idx    = '0;
      free_found   = 1'b0;
      free_idx     = '0;

      for (int i = 0; i < int'(NBUF); i++) begin
         if (bank_st[i] == BANK_READY) begin
            ready_found = 1'b1;
            ready_idx   = BW'(i);
         end
      end

      commit_ok = wr_commit && !wr_wait;
      if (commit_ok) begin
         if (ready_found) begin
            st_nxt[ready_idx] = BANK_FREE;
            overrun_hit       = 1'b1;
         end
         st_nxt[wr_bank_q] = BANK_READY;
      end

      deliver     = rd_swap && (commit_ok || ready_found);
      deliver_idx = commit_ok ? wr_bank_q : ready_idx;
      rd_release  = rd_swap && rd_valid && (deliver || !REPEAT_EN);
      if (rd_release) st_nxt[rd_bank_q] = BANK_FREE;

      if (deliver) begin
         st_nxt[deliver_idx] = BANK_READING;
         rd_bank_nxt         = deliver_idx;
         rd_valid_nxt        = 1'b1;
         fresh_nxt           = 1'b1;
      end else if (rd_swap) begin
         underrun_hit = 1'b1;
         fresh_nxt    = 1'b0;
         if (rd_release) rd_valid_nxt = 1'b0;
      end

      // A waiting writer only sees banks already free at the start of this cycle.
      if (commit_ok || wr_wait) begin
         for (int i = int'(NBUF) - 1; i >= 0; i--) begin
            if ((commit_ok ? st_nxt[i] : bank_st[i]) == BANK_FREE) begin
               free_found = 1'b1;
               free_idx   = BW'(i);
            end
         end
         if (commit_ok && deliver && rd_release) begin
            free_found = 1'b1;
            free_idx   = rd_bank_q;
         end
         if (free_found) begin
            st_nxt[free_idx] = BANK_FILLING;
            wr_bank_nxt      = free_idx;
            wr_wait_nxt      = 1'b0;
         end else begin
            wr_wait_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NBUF); i++) bank_st[i] <= (i == 0) ? BANK_FILLING : BANK_FREE;
         wr_bank_q    <= '0;
         rd_bank_q    <= '0;
         wr_wait      <= 1'b0;
         rd_valid     <= 1'b0;
         frame_fresh  <= 1'b0;
         fill_sel     <= 1'b1;
         overrun_cnt  <= '0;
         underrun_cnt <= '0;
         drop_cnt     <= '0;
      end else begin
         bank_st      <= st_nxt;
         wr_bank_q    <= wr_bank_nxt;
         rd_bank_q    <= rd_bank_nxt;
         wr_wait      <= wr_wait_nxt;
         rd_valid     <= rd_valid_nxt;
         frame_fresh  <= fresh_nxt;
         if (rd_en) fill_sel <= !rd_valid;
         overrun_cnt  <= sat_inc(overrun_cnt, overrun_hit);
         underrun_cnt <= sat_inc(underrun_cnt, underrun_hit);
         drop_cnt     <= sat_inc(drop_cnt, drop_hit);
      end
   end

   orb_bank_ram #(
      .WORD_W (WORD_W),
      .ADDR_W (BW + AW),
      .NWORDS (MEM_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr ({wr_bank_q, wr_addr}),
      .wdata (wr_data),
      .re    (ram_re),
      .raddr ({rd_bank_q, rd_addr}),
      .rdata (ram_q)
   );

endmodule

// File: doc/orb_frame_buffer.md
ORB_FRAME_BUFFER -- requirements
Module: orb_frame_buffer

Interface
REQ-001 Parameter WORD_W, default 12, width of one orbit word.
REQ-002 Parameter DEPTH, default 2048, words per bank; SHALL be a power of two; AW = clog2(DEPTH).
REQ-003 Parameter NBUF, default 2, number of banks, legal range 2..4.
REQ-004 Parameter REPEAT_EN, default 1, underrun policy: 1 = repeat last frame, 0 = blank.
REQ-005 Parameter FILL_WORD, default 0, rd_data value while no bank is held by the reader.
REQ-006 Clocking: one clock; reset is asynchronous and active-low. Ports: clk  in  1  sole clock; rst  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  write strobe; wr_addr  in  AW  word address; wr_data  in  WORD_W  word.
REQ-008 wr_commit  in  1  one-cycle pulse, current write bank holds a complete frame.
REQ-009 rd_en  in  1  read strobe; rd_addr  in  AW  word address; rd_data  out  WORD_W  registered read word.
REQ-010 rd_swap  in  1  one-cycle pulse at orbit frame boundary, reader requests newest frame.
REQ-011 rd_valid  out  1  reader holds a bank; frame_fresh  out  1  last rd_swap delivered a new frame.
REQ-012 wr_bank, rd_bank  out  2 each  bank indices; wr_wait  out  1  writer has no bank.
REQ-013 overrun_cnt, underrun_cnt, drop_cnt  out  16 each  saturating event counters.

Function
REQ-014 Each bank SHALL be in exactly one state: FREE, FILLING, READY, READING; at most one READY bank at any time.
REQ-015 wr_en with writer not waiting SHALL store wr_data at {wr_bank, wr_addr} in the same clock edge.
REQ-016 wr_en while wr_wait=1 SHALL be discarded and drop_cnt incremented once per strobe.
REQ-017 wr_commit: FILLING bank becomes READY; a previously READY bank becomes FREE and overrun_cnt increments.
REQ-018 After commit the writer SHALL take the lowest-index FREE bank as FILLING; if none, wr_wait=1 until one is freed, then take it the cycle after it frees.
REQ-019 wr_commit while wr_wait=1 SHALL be ignored.
REQ-020 rd_swap with a READY bank: reader's current bank becomes FREE, READY bank becomes READING, rd_valid=1, frame_fresh=1.
REQ-021 rd_swap with no READY bank, REPEAT_EN=1: reader keeps its bank, frame_fresh=0, underrun_cnt increments.
REQ-022 rd_swap with no READY bank, REPEAT_EN=0: reader releases its bank to FREE, rd_valid=0, frame_fresh=0, underrun_cnt increments.
REQ-023 rd_swap with no READY bank while rd_valid=0: underrun_cnt increments, state unchanged.
REQ-024 Same-cycle wr_commit and rd_swap: commit SHALL be resolved first, reader takes the just-committed bank, writer takes the bank released by the reader (pure ping-pong for NBUF=2); no overrun, no underrun counted.
REQ-025 rd_data SHALL update one cycle after rd_en with word {rd_bank, rd_addr}; holds value when rd_en=0; equals FILL_WORD when rd_valid=0 at the rd_en cycle.
REQ-026 Same-cycle write and read of identical {bank, addr} cannot occur (reader never owns FILLING bank); no bypass required.
REQ-027 Counters SHALL saturate at 16'hFFFF; no wrap.
REQ-028 Address arithmetic SHALL be {bank, addr} concatenation, no overflow handling; addresses wrap naturally within DEPTH.

Reset
REQ-029 On rst=0, asynchronously: bank 0 FILLING, all others FREE, wr_bank=0, rd_bank=0, rd_valid=0, frame_fresh=0, wr_wait=0, all counters 0, rd_data=FILL_WORD.
REQ-030 Reset mid-frame SHALL abandon all frames; memory contents need not be cleared.
REQ-031 Reset release SHALL take effect on the first clk edge with rst=1; no strobe in that cycle is lost.

Structure
REQ-032 Package orb_buf_pkg SHALL hold the bank-state enum, counter width (16) and parameter defaults.
REQ-033 Storage SHALL be one sub-module orb_bank_ram: simple dual-port, NBUF*DEPTH x WORD_W, registered read, single clock, no reset.
REQ-034 Bank-state tracking and counters SHALL reside in orb_frame_buffer.

Verification
REQ-035 NBUF=2: write 0..2047 = addr, commit with rd_swap same cycle -> rd_bank=0, rd_valid=1, read addr 5 gives 5 one cycle later, wr_bank=1.
REQ-036 NBUF=3: two commits without rd_swap -> overrun_cnt=1, second frame delivered on next rd_swap, frame_fresh=1.
REQ-037 REPEAT_EN=1, rd_swap with no READY bank -> rd_bank unchanged, frame_fresh=0, underrun_cnt=1; REPEAT_EN=0 -> rd_valid=0, rd_data=FILL_WORD.
REQ-038 NBUF=2: commit, then 10 wr_en before rd_swap -> wr_wait=1, drop_cnt=10; after rd_swap wr_wait=0 next cycle.
REQ-039 Assert rst=0 mid-frame asynchronously -> all outputs at REQ-029 values before next clk edge.
REQ-040 Force 70000 underruns -> underrun_cnt stays 16'hFFFF.
